// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational imem and
// buffers one fetched word for decode behind a valid/ready handshake.
module imem_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int PROG_LEN = 11,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic [7:0]         fetch_count
);

    // One extra bit so PROG_LEN = 2^ADDR_W is representable and never reached.
    localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              vld_nxt;
    logic              load;
    logic              accept;
    logic              in_range;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept    = out_valid & out_ready;
    assign in_range  = {1'b0, pc} < PROG_END;
    assign imem_addr = pc;
    assign halted    = (state == DONE);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        vld_nxt   = out_valid;
        load      = 1'b0;
        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (run) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    vld_nxt = 1'b0;
                    pc_nxt  = redirect_pc;
                end else if (!in_range) begin
                    state_nxt = DRAIN;
                    if (accept) vld_nxt = 1'b0;
                end else if (!out_valid || out_ready) begin
                    load    = 1'b1;
                    vld_nxt = 1'b1;
                    pc_nxt  = pc + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // A redirect may pull us back into the program even while draining.
                if (redirect_valid) begin
                    state_nxt = RUN;
                    vld_nxt   = 1'b0;
                    pc_nxt    = redirect_pc;
                end else if (!out_valid || out_ready) begin
                    state_nxt = DONE;
                    vld_nxt   = 1'b0;
                end
            end
            DONE: begin
                vld_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            pc          <= START_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fetch_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            out_valid <= vld_nxt;
            if (load) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
            end
            // A handshake in a redirect cycle still counts as delivered.
            if (accept) fetch_count <= sat_inc(fetch_count);
        end
    end

endmodule
